aud_apb_master: RTL
===================

# aud_apb_master

APB4 initiator that converts a simple valid/ready request/response interface into single APB transfers. It is the bus-side counterpart of the peripheral APB wrappers: test harnesses and small sequencers use it to drive register accesses, for example start/reset writes to the audio PWM peripheral, without hand-sequencing PSEL/PENABLE. It issues one transfer at a time, captures PRDATA/PSLVERR, and optionally aborts transfers that stall.

## Interface
- TIMEOUT_CYCLES, 256: maximum ACCESS-phase cycles with pready_i low before abort; legal range 2..65535.
- pclk_i  in  1  clock; all logic on rising edge.
- presetn_i  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted this cycle when high together with req_valid_i.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  write data.
- req_strb_i  in  4  write byte strobes.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  32  read data; 0 for writes and errors.
- rsp_err_o  out  1  PSLVERR seen, misaligned address, or timeout.
- rsp_timeout_o  out  1  transfer aborted by timeout.
- paddr_o  out  32  APB address.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- pwdata_o  out  32  APB write data.
- pstrb_o  out  4  APB strobes; forced to 0 for reads.
- pready_i  in  1  APB ready.
- prdata_i  in  32  APB read data.
- pslverr_i  in  1  APB error, sampled only with pready_i.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered or decoded from state.
- IDLE: req_ready_o=1. On req_valid_i, latch all request fields. If req_addr_i[1:0]!=0, go to RESP with err=1 and no bus activity. Otherwise go to SETUP.
- SETUP: psel_o=1, penable_o=0, address/control/data driven from latched fields. Next state is always ACCESS.
- ACCESS: psel_o=1, penable_o=1, with bus fields unchanged from SETUP.
  - On pready_i=1: capture prdata_i (reads only) and pslverr_i, then go to RESP.
  - On pready_i=0: stay in ACCESS and increment the wait counter.
- RESP: psel_o=0, penable_o=0, rsp_valid_o=1, response fields stable. On rsp_ready_i, return to IDLE.
- Read with pslverr_i=1: rsp_rdata_o=0, rsp_err_o=1.
- A write with req_strb_i=0 is still issued on the bus.
- Bus outputs hold their last value when psel_o=0; only psel_o/penable_o qualify them.

## Timing
- Reset values:
  - Outputs: req_ready_o=1, rsp_valid_o=0, psel_o=0, penable_o=0, pwrite_o=0, paddr_o=0, pwdata_o=0, pstrb_o=0, rsp_rdata_o=0, rsp_err_o=0, rsp_timeout_o=0.
  - Internal: state IDLE, wait counter 0.
- Request accepted at edge N:
  - SETUP visible in cycle N+1.
  - ACCESS visible in cycle N+2.
  - With zero wait states, rsp_valid_o is high in cycle N+3.
- Each low-pready ACCESS cycle adds one cycle of latency.
- Misaligned request accepted at edge N: rsp_valid_o is high in cycle N+1.
- Throughput: the next request is accepted no earlier than the cycle after the rsp_valid_o/rsp_ready_i handshake. Minimum 4 cycles per transfer.
- Wait counter: cleared on entering ACCESS; counts ACCESS cycles with pready_i=0; width is $clog2(TIMEOUT_CYCLES+1).
- Reset asserted mid-transfer: psel_o/penable_o drop immediately (asynchronously), any pending response is discarded, and the FSM returns to IDLE.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - If pready_i is still 0 in the TIMEOUT_CYCLES-th ACCESS cycle, abort.
  - Next cycle: psel_o=0, RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
  - pready_i=1 in that same cycle wins: normal completion, no timeout.
- APB_MASTER_TIMEOUT_EN undefined: no counter is instantiated, ACCESS waits indefinitely, and rsp_timeout_o is tied to 0.

## Test plan
- Zero-wait write: addr 0x4, data 0x0000_0001, strb 0xF.
  - SETUP at N+1, ACCESS at N+2 with pstrb_o=0xF, rsp_valid_o at N+3.
  - rsp_err_o=0, rsp_rdata_o=0.
- Read with 3 wait states: prdata_i=0xDEAD_BEEF.
  - psel_o high for 5 cycles.
  - rsp_rdata_o=0xDEAD_BEEF at N+6, pstrb_o=0.
- Read with pslverr_i=1 and pready_i=1: rsp_err_o=1, rsp_rdata_o=0, rsp_timeout_o=0.
- Misaligned addr 0x6:
  - psel_o never asserts.
  - rsp_valid_o at N+1 with rsp_err_o=1.
- Timeout (macro defined, TIMEOUT_CYCLES=4, pready_i held 0):
  - 4 ACCESS cycles, then rsp_err_o=1 and rsp_timeout_o=1.
  - Repeat with pready_i=1 on the 4th ACCESS cycle: normal completion.
- Reset mid-ACCESS and held rsp_ready_i=0:
  - presetn_i low during ACCESS: psel_o=0 before the next edge, all outputs return to reset values.
  - Separately, a response held with rsp_ready_i=0 for 10 cycles stays stable and req_ready_o stays 0.

Source files
------------

// File: rtl/aud_apb_master.sv
// -----------------------------------------------------------------------------
// aud_apb_master
//
// APB4 initiator. Converts a valid/ready request/response handshake into one
// APB transfer at a time (SETUP then ACCESS), captures PRDATA/PSLVERR and
// presents a single registered response until it is consumed.
//
// Misaligned requests (addr[1:0] != 0) never reach the bus; they return an
// error response one cycle after acceptance.
//
// Optional feature (compile-time macro APB_MASTER_TIMEOUT_EN):
//   defined   - a wait counter aborts a transfer whose pready_i is still low in
//               the TIMEOUT_CYCLES-th ACCESS cycle; the response reports
//               rsp_err_o=1 and rsp_timeout_o=1.
//   undefined - no counter exists, ACCESS waits indefinitely and
//               rsp_timeout_o is tied low.
//
// Parameters
//   TIMEOUT_CYCLES  ACCESS cycles with pready_i low before abort (2..65535)
//
// Ports
//   pclk_i, presetn_i          clock (rising edge), async active-low reset
//   req_valid_i / req_ready_o  request handshake
//   req_write_i                1 = write, 0 = read
//   req_addr_i                 byte address (must be word aligned)
//   req_wdata_i, req_strb_i    write data and byte strobes
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_rdata_o                read data (0 for writes and all errors)
//   rsp_err_o                  PSLVERR, misalignment or timeout
//   rsp_timeout_o              transfer aborted by the wait counter
//   paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o   APB request
//   pready_i, prdata_i, pslverr_i                             APB completion
// -----------------------------------------------------------------------------
module aud_apb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        pclk_i,
    input  logic        presetn_i,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_strb_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,

    output logic [31:0] paddr_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    output logic [3:0]  pstrb_o,
    input  logic        pready_i,
    input  logic [31:0] prdata_i,
    input  logic        pslverr_i
);

    // Reject out-of-range configurations at elaboration time.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("aud_apb_master: TIMEOUT_CYCLES must be in 2..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e      state_q,  state_d;

    // Bus-side request fields; they hold between transfers, psel_o qualifies.
    logic [31:0] paddr_q,  paddr_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [3:0]  pstrb_q,  pstrb_d;

    // Response fields, stable for the whole RESP phase.
    logic [31:0] rdata_q,  rdata_d;
    logic        err_q,    err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q,  timeout_d;
    logic             timeout_hit;

    // The counter holds the number of low-pready ACCESS cycles already seen,
    // so a value of TIMEOUT_CYCLES-1 means this is the TIMEOUT_CYCLES-th one.
    assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // through the case can leave it unassigned and infer a latch.
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    paddr_d  = req_addr_i;
                    pwrite_d = req_write_i;
                    pwdata_d = req_wdata_i;
                    // Reads never carry strobes on the bus.
                    pstrb_d  = req_write_i ? req_strb_i : 4'b0000;
                    if (req_addr_i[1:0] != 2'b00) begin
                        // Misaligned: answer immediately, no bus activity.
                        rdata_d = '0;
                        err_d   = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                        timeout_d = 1'b0;
`endif
                        state_d = S_RESP;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end

            S_SETUP: begin
`ifdef APB_MASTER_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                state_d = S_ACCESS;
            end

            S_ACCESS: begin
                if (pready_i) begin
                    // An erroring read returns zero rather than bus garbage.
                    rdata_d = (!pwrite_q && !pslverr_i) ? prdata_i : '0;
                    err_d   = pslverr_i;
`ifdef APB_MASTER_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d = S_RESP;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (timeout_hit) begin
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end

            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q  <= S_IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign rsp_timeout_o = timeout_q;
`else
    assign rsp_timeout_o = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs: handshake and bus qualifiers are decoded from the state register,
    // so an asynchronous reset drops psel_o/penable_o immediately.
    // -------------------------------------------------------------------------
    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign psel_o      = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign penable_o   = (state_q == S_ACCESS);

    assign paddr_o     = paddr_q;
    assign pwrite_o    = pwrite_q;
    assign pwdata_o    = pwdata_q;
    assign pstrb_o     = pstrb_q;

    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule
